// File: rtl/mc_main_ctrl.sv
// Multicycle MIPS main controller: state register plus decoded datapath/memory/ALU controls.
// Optional andi/ori support (zero-extended immediates) is enabled by defining MC_IMM_LOGIC_EN.
module mc_main_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [3:0] alu_control,
  output logic       ext_zero,
  output logic       illegal,
  output logic       bus_err
);

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1010;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [7:0] TMO_LAST = 8'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_RST, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_RTYPE,
    S_ALUWB, S_BEQ, S_ADDI, S_ADDIWB, S_JUMP, S_ANDIEX, S_ORIEX
  } state_t;

  state_t     state;
  state_t     dec_next;
  logic [7:0] cnt;
  logic       in_wait, tmo, op_ok, r_ok;
  logic [3:0] r_alu;

  assign in_wait = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
  // a ready in the timeout cycle still completes the access normally
  assign tmo = (MEM_TIMEOUT != 0) && in_wait && !mem_ready && (cnt == TMO_LAST);

  always_comb begin
    op_ok    = 1'b1;
    dec_next = S_FETCH;
    case (opcode)
      6'h23, 6'h2B: dec_next = S_MEMADR;
      6'h00:        dec_next = S_RTYPE;
      6'h04:        dec_next = S_BEQ;
      6'h08:        dec_next = S_ADDI;
      6'h02:        dec_next = S_JUMP;
`ifdef MC_IMM_LOGIC_EN
      6'h0C:        dec_next = S_ANDIEX;
      6'h0D:        dec_next = S_ORIEX;
`endif
      default:      op_ok    = 1'b0;
    endcase
  end

  always_comb begin
    r_ok  = 1'b1;
    r_alu = ALU_AND;
    case (funct)
      6'h20:   r_alu = ALU_ADD;
      6'h22:   r_alu = ALU_SUB;
      6'h24:   r_alu = ALU_AND;
      6'h25:   r_alu = ALU_OR;
      6'h27:   r_alu = ALU_NOR;
      6'h2A:   r_alu = ALU_SLT;
      6'h00:   r_alu = ALU_SLL;
      default: r_ok  = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_RST;
      cnt   <= '0;
    end else begin
      cnt <= (in_wait && !mem_ready && !tmo) ? cnt + 8'd1 : 8'd0;
      case (state)
        S_RST:    state <= S_FETCH;
        S_FETCH:  if (mem_ready) state <= S_DECODE;
        S_DECODE: state <= dec_next;
        S_MEMADR: state <= (opcode == 6'h2B) ? S_MEMWR : S_MEMRD;
        S_MEMRD:  if (mem_ready) state <= S_MEMWB; else if (tmo) state <= S_FETCH;
        S_MEMWR:  if (mem_ready || tmo) state <= S_FETCH;
        S_RTYPE:  state <= r_ok ? S_ALUWB : S_FETCH;
        S_ADDI:   state <= S_ADDIWB;
`ifdef MC_IMM_LOGIC_EN
        S_ANDIEX: state <= S_ADDIWB;
        S_ORIEX:  state <= S_ADDIWB;
`endif
        default:  state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    pc_en       = 1'b0;
    iord        = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    pc_src      = 2'b00;
    alu_control = ALU_AND;
    ext_zero    = 1'b0;
    illegal     = 1'b0;
    bus_err     = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read    = 1'b1;
        alu_src_b   = 2'b01;
        alu_control = ALU_ADD;
        ir_write    = mem_ready;
        pc_en       = mem_ready;
        bus_err     = tmo;
      end
      S_DECODE: begin
        alu_src_b   = 2'b11;
        alu_control = ALU_ADD;
        illegal     = !op_ok;
      end
      S_MEMADR, S_ADDI: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        alu_control = ALU_ADD;
      end
      S_MEMRD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        bus_err  = tmo;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        bus_err   = tmo;
      end
      S_RTYPE: begin
        alu_src_a   = 1'b1;
        alu_control = r_alu;
        illegal     = !r_ok;
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_BEQ: begin
        alu_src_a   = 1'b1;
        alu_control = ALU_SUB;
        pc_src      = 2'b01;
        pc_en       = zero;
      end
      S_ADDIWB: reg_write = 1'b1;
      S_JUMP: begin
        pc_src = 2'b10;
        pc_en  = 1'b1;
      end
`ifdef MC_IMM_LOGIC_EN
      S_ANDIEX, S_ORIEX: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        ext_zero    = 1'b1;
        alu_control = (state == S_ORIEX) ? ALU_OR : ALU_AND;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Directed bench for mc_main_ctrl: one instance with MEM_TIMEOUT=4, one waiting forever.
module tb_mc_main_ctrl;
  logic       clk = 1'b0;
  logic       rst_n, zero, mem_ready;
  logic [5:0] opcode, funct;

  logic       pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic       alu_src_a, ext_zero, illegal, bus_err;
  logic [1:0] alu_src_b, pc_src;
  logic [3:0] alu_control;

  logic       i_pc_en, i_iord, i_mem_read, i_mem_write, i_ir_write, i_reg_dst, i_mem_to_reg;
  logic       i_reg_write, i_alu_src_a, i_ext_zero, i_illegal, i_bus_err;
  logic [1:0] i_alu_src_b, i_pc_src;
  logic [3:0] i_alu_control;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  mc_main_ctrl #(.MEM_TIMEOUT(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_en(pc_en), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
    .alu_control(alu_control), .ext_zero(ext_zero), .illegal(illegal), .bus_err(bus_err)
  );

  mc_main_ctrl u_inf (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_en(i_pc_en), .iord(i_iord), .mem_read(i_mem_read),
    .mem_write(i_mem_write), .ir_write(i_ir_write), .reg_dst(i_reg_dst),
    .mem_to_reg(i_mem_to_reg), .reg_write(i_reg_write), .alu_src_a(i_alu_src_a),
    .alu_src_b(i_alu_src_b), .pc_src(i_pc_src), .alu_control(i_alu_control),
    .ext_zero(i_ext_zero), .illegal(i_illegal), .bus_err(i_bus_err)
  );

  logic [19:0] outw, outi;
  assign outw = {pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                 alu_src_a, alu_src_b, pc_src, alu_control, ext_zero, illegal, bus_err};
  assign outi = {i_pc_en, i_iord, i_mem_read, i_mem_write, i_ir_write, i_reg_dst, i_mem_to_reg,
                 i_reg_write, i_alu_src_a, i_alu_src_b, i_pc_src, i_alu_control, i_ext_zero,
                 i_illegal, i_bus_err};

  function automatic logic [19:0] ow(input logic pe, io, mr, mw, irw, rd, mtr, rw, sa,
                                     input logic [1:0] sb, ps, input logic [3:0] ac,
                                     input logic il, be);
    return {pe, io, mr, mw, irw, rd, mtr, rw, sa, sb, ps, ac, 1'b0, il, be};
  endfunction

  task automatic chk(input string tag, input logic [19:0] got, input logic [19:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %b want %b", tag, got, exp);
    end
  endtask

  // inputs are changed at the falling edge; outputs sampled 1 time unit later
  task automatic cyc(input string tag, input logic [19:0] exp);
    #1;
    chk(tag, outw, exp);
    @(negedge clk);
  endtask

  logic [19:0] e_zero, e_fwait, e_frdy, e_ftmo, e_dec, e_decill, e_memadr, e_memrd, e_memwb;
  logic [19:0] e_memwr, e_memwrto, e_rill, e_aluwb, e_addiwb, e_jump;

  function automatic logic [19:0] e_rtype(input logic [3:0] ac);
    return ow(0,0,0,0,0,0,0,0,1, 2'b00, 2'b00, ac, 0,0);
  endfunction

  function automatic logic [19:0] e_beq(input logic z);
    return ow(z,0,0,0,0,0,0,0,1, 2'b00, 2'b01, 4'b0110, 0,0);
  endfunction

  task automatic fd(input logic [5:0] op, input logic [5:0] fn);
    opcode = op; funct = fn; mem_ready = 1'b1;
    cyc("fetch", e_frdy);
    cyc("decode", e_dec);
  endtask

  logic [5:0] rf [7];
  logic [3:0] ra [7];

  initial begin
    e_zero    = '0;
    e_fwait   = ow(0,0,1,0,0,0,0,0,0, 2'b01, 2'b00, 4'b0010, 0,0);
    e_frdy    = ow(1,0,1,0,1,0,0,0,0, 2'b01, 2'b00, 4'b0010, 0,0);
    e_ftmo    = ow(0,0,1,0,0,0,0,0,0, 2'b01, 2'b00, 4'b0010, 0,1);
    e_dec     = ow(0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 4'b0010, 0,0);
    e_decill  = ow(0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 4'b0010, 1,0);
    e_memadr  = ow(0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 4'b0010, 0,0);
    e_memrd   = ow(0,1,1,0,0,0,0,0,0, 2'b00, 2'b00, 4'b0000, 0,0);
    e_memwb   = ow(0,0,0,0,0,0,1,1,0, 2'b00, 2'b00, 4'b0000, 0,0);
    e_memwr   = ow(0,1,0,1,0,0,0,0,0, 2'b00, 2'b00, 4'b0000, 0,0);
    e_memwrto = ow(0,1,0,1,0,0,0,0,0, 2'b00, 2'b00, 4'b0000, 0,1);
    e_rill    = ow(0,0,0,0,0,0,0,0,1, 2'b00, 2'b00, 4'b0000, 1,0);
    e_aluwb   = ow(0,0,0,0,0,1,0,1,0, 2'b00, 2'b00, 4'b0000, 0,0);
    e_addiwb  = ow(0,0,0,0,0,0,0,1,0, 2'b00, 2'b00, 4'b0000, 0,0);
    e_jump    = ow(1,0,0,0,0,0,0,0,0, 2'b00, 2'b10, 4'b0000, 0,0);
    rf = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h00};
    ra = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1100, 4'b0111, 4'b1010};

    rst_n = 1'b0; zero = 1'b0; mem_ready = 1'b0; opcode = '0; funct = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc("rst_state", e_zero);
    cyc("rst_fetch", e_fwait);

    // R-type table
    for (int i = 0; i < 7; i++) begin
      fd(6'h00, rf[i]);
      cyc($sformatf("rtype_%h", rf[i]), e_rtype(ra[i]));
      cyc("aluwb", e_aluwb);
    end

    // lw with three wait cycles; ready arrives on the cycle the timeout would fire
    fd(6'h23, 6'h00);
    cyc("lw_memadr", e_memadr);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc("lw_memrd_wait", e_memrd);
    mem_ready = 1'b1;
    cyc("lw_memrd_rdy", e_memrd);
    cyc("lw_memwb", e_memwb);

    fd(6'h04, 6'h00); zero = 1'b1;
    cyc("beq_taken", e_beq(1'b1));
    fd(6'h04, 6'h00); zero = 1'b0;
    cyc("beq_not", e_beq(1'b0));

    fd(6'h08, 6'h00);
    cyc("addi", e_memadr);
    cyc("addiwb", e_addiwb);

    fd(6'h02, 6'h00);
    cyc("jump", e_jump);

    opcode = 6'h3F; mem_ready = 1'b1;
    cyc("fetch", e_frdy);
    cyc("dec_illegal", e_decill);
    cyc("after_illop", e_frdy);
    opcode = 6'h0C;
    cyc("dec_andi_off", e_decill);
    cyc("after_andi", e_frdy);
    opcode = 6'h00; funct = 6'h3F;
    cyc("decode", e_dec);
    cyc("rtype_illegal", e_rill);
    cyc("after_illfn", e_frdy);

    // sw completing immediately
    opcode = 6'h2B; funct = 6'h00;
    cyc("decode", e_dec);
    cyc("sw_memadr", e_memadr);
    cyc("sw_memwr", e_memwr);

    // sw timeout, then a fetch timeout
    fd(6'h2B, 6'h00);
    cyc("sw_memadr", e_memadr);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc("sw_memwr_wait", e_memwr);
    cyc("sw_bus_err", e_memwrto);
    for (int i = 0; i < 3; i++) cyc("fetch_wait", e_fwait);
    cyc("fetch_bus_err", e_ftmo);
    cyc("fetch_retry", e_fwait);
    #1;
    chk("inf_still_memwr", outi, e_memwr);

    // reset in the middle of a store
    @(negedge clk);
    mem_ready = 1'b1;
    cyc("fetch", e_frdy);
    cyc("decode", e_dec);
    cyc("sw_memadr", e_memadr);
    mem_ready = 1'b0;
    cyc("sw_memwr", e_memwr);
    rst_n = 1'b0;
    cyc("sw_memwr_rst", e_memwr);
    rst_n = 1'b1;
    #1;
    chk("inf_rst", outi, e_zero);
    cyc("mid_rst", e_zero);
    mem_ready = 1'b1;
    cyc("post_rst_fetch", e_frdy);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
